// File: rtl/fifo_write_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// fifo_write_arbiter_pkg
// Shared types and helpers for the FIFO write arbiter and the arbiters that
// reuse its round-robin picker.
//   arb_state_t : IDLE (arbitrating / waiting for room) or BURST (owner writes)
//   clog2       : ceiling log2 usable in parameter and port declarations
//   fifo_cap    : number of entries of a FIFO with the given address width
//   FIFO_CAP    : capacity of the default 4-bit-address FIFO
// ----------------------------------------------------------------------------
package fifo_write_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int DEFAULT_ADDR_WIDTH = 4;
    localparam int FIFO_CAP           = 2 ** DEFAULT_ADDR_WIDTH;

    // Ceiling log2; clog2(1) = 0, clog2(5) = 3.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int fifo_cap(input int addr_width);
        return 2 ** addr_width;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_picker.sv
// ----------------------------------------------------------------------------
// rr_priority_picker
// Purely combinational round-robin search: returns the first requester found
// when scanning rr_ptr, rr_ptr+1, ... wrapping modulo N (N need not be a
// power of two).
// Ports:
//   req    in  N      request vector
//   rr_ptr in  IDX_W  index to start the search at (must be < N)
//   found  out 1      at least one request bit set
//   idx    out IDX_W  winning index (0 when nothing is found)
// ----------------------------------------------------------------------------
module rr_priority_picker
    import fifo_write_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Wrap base+offset back into 0..N-1; base < N and offset < N so a single
    // subtraction is enough.
    function automatic int rot_index(input int base, input int offset);
        int sum;
        sum = base + offset;
        if (sum >= N) begin
            sum = sum - N;
        end
        return sum;
    endfunction

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[IDX_W'(rot_index(int'(rr_ptr), k))]) begin
                found = 1'b1;
                idx   = IDX_W'(rot_index(int'(rr_ptr), k));
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// ----------------------------------------------------------------------------
// fifo_write_arbiter
// Shares the write side of one single-clock FIFO among NUM_REQ producers.
// A round-robin arbiter hands one producer a burst of up to BURST_LEN words,
// and only when the FIFO has room for the whole burst.
//
// Producer handshake: req[i] says the word on producer i's req_data slice is
// valid; gnt[i] says that word is written to the FIFO in this cycle (the
// producer advances to its next word after a cycle with req[i] & gnt[i]).
// req_last[i] marks the last word of the burst and is only looked at on a
// granted beat. gnt is one-hot or zero and only ever set for the owner.
//
// Ports:
//   clk, reset     clock; synchronous active-high reset
//   req            per-producer word valid
//   req_data       flattened words, producer i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last       per-producer end-of-burst marker
//   gnt            one-hot write grant
//   fifo_depth     FIFO occupancy (wraps to 0 when full)
//   fifo_full      FIFO full flag
//   fifo_wen       FIFO write enable
//   fifo_data_in   FIFO write data (owner's slice)
//   owner          current / most recent burst owner
//   busy           high while a burst is open
//   dbg_state      FSM state
//   dbg_rr_ptr     round-robin search start
// ----------------------------------------------------------------------------
module fifo_write_arbiter
    import fifo_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int BURST_LEN  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic [ADDR_WIDTH-1:0]         fifo_depth,
    input  logic                          fifo_full,
    output logic                          fifo_wen,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic [clog2(NUM_REQ)-1:0]     owner,
    output logic                          busy,
    output arb_state_t                    dbg_state,
    output logic [clog2(NUM_REQ)-1:0]     dbg_rr_ptr
);

    localparam int OW  = clog2(NUM_REQ);
    localparam int BW  = clog2(BURST_LEN + 1);
    localparam int FW  = ADDR_WIDTH + 1;
    localparam int CAP = fifo_cap(ADDR_WIDTH);

    arb_state_t    r_state;
    arb_state_t    w_state_next;
    logic [OW-1:0] r_owner;
    logic [OW-1:0] w_owner_next;
    logic [OW-1:0] r_rr_ptr;
    logic [OW-1:0] w_rr_next;
    logic [BW-1:0] r_beat_cnt;
    logic [BW-1:0] w_beat_next;
    logic [BW-1:0] w_beat_inc;

    logic          w_pick_found;
    logic [OW-1:0] w_pick_idx;
    logic [FW-1:0] w_free_space;
    logic          w_start;
    logic          w_grant_beat;
    logic          w_burst_end;

    // fifo_depth wraps to 0 when the FIFO is full, so the full flag has to
    // override the subtraction.
    assign w_free_space = fifo_full ? '0 : (FW'(CAP) - {1'b0, fifo_depth});

    rr_priority_picker #(
        .N     (NUM_REQ),
        .IDX_W (OW)
    ) u_picker (
        .req    (req),
        .rr_ptr (r_rr_ptr),
        .found  (w_pick_found),
        .idx    (w_pick_idx)
    );

    assign w_start = (r_state == IDLE) && w_pick_found
                     && (w_free_space >= FW'(BURST_LEN));

    // Grant only the owner's word. ~fifo_full is a safety gate (the entry
    // check already reserves room); ~reset keeps a beat presented in the
    // reset cycle from being written.
    always_comb begin
        gnt = '0;
        if ((r_state == BURST) && !reset) begin
            gnt[r_owner] = req[r_owner] & ~fifo_full;
        end
    end

    assign fifo_wen     = |gnt;
    assign fifo_data_in = req_data[int'(r_owner)*DATA_WIDTH +: DATA_WIDTH];

    assign w_grant_beat = fifo_wen;
    assign w_beat_inc   = r_beat_cnt + 1'b1;
    assign w_burst_end  = w_grant_beat
                          && (req_last[r_owner] || (w_beat_inc == BW'(BURST_LEN)));

    always_comb begin
        w_state_next = r_state;
        w_owner_next = r_owner;
        w_rr_next    = r_rr_ptr;
        w_beat_next  = r_beat_cnt;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_next = BURST;
                    w_owner_next = w_pick_idx;
                    w_beat_next  = '0;
                end
            end
            BURST: begin
                if (w_grant_beat) begin
                    w_beat_next = w_beat_inc;
                    if (w_burst_end) begin
                        w_state_next = IDLE;
                        // Explicit wrap so non-power-of-2 NUM_REQ works.
                        w_rr_next = (r_owner == OW'(NUM_REQ - 1)) ? '0 : (r_owner + 1'b1);
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_owner    <= w_owner_next;
            r_rr_ptr   <= w_rr_next;
            r_beat_cnt <= w_beat_next;
        end
    end

    assign owner      = r_owner;
    assign busy       = (r_state == BURST);
    assign dbg_state  = r_state;
    assign dbg_rr_ptr = r_rr_ptr;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
module tb_fifo_write_arbiter;
  import fifo_write_arbiter_pkg::*;

  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int AW  = 4;
  localparam int BL  = 4;
  localparam int CAP = 16;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    gnt;
  logic [AW-1:0]   fifo_depth;
  logic            fifo_full;
  logic            fifo_wen;
  logic [DW-1:0]   fifo_data_in;
  logic [1:0]      owner;
  logic            busy;
  arb_state_t      dbg_state;
  logic [1:0]      dbg_rr_ptr;

  fifo_write_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .req_last(req_last), .gnt(gnt), .fifo_depth(fifo_depth),
    .fifo_full(fifo_full), .fifo_wen(fifo_wen), .fifo_data_in(fifo_data_in),
    .owner(owner), .busy(busy), .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
  );

  int checks = 0;
  int failures = 0;

  // fifo_q: words the DUT actually wrote; exp_q: expected FIFO contents
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic rd_en;

  // behavioural reference: is a burst open, who owns it, next search start,
  // words written so far in the burst
  bit m_busy;
  int m_owner, m_rr, m_cnt;
  int p_cnt[N];
  logic [N-1:0] last_gnt;
  logic last_wen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      if (r[(start + k) % N]) return (start + k) % N;
    end
    return 0;
  endfunction

  // driver + per-cycle check; entered and left at a negedge
  task automatic cyc();
    logic [N-1:0]  exp_gnt;
    logic [DW-1:0] exp_word;
    logic [DW-1:0] d_seen;
    int free;
    bit grant;
    fifo_depth = AW'(fifo_q.size() % CAP);
    fifo_full  = (fifo_q.size() == CAP);
    free = CAP - fifo_q.size();
    #1;
    exp_gnt = '0;
    grant = 0;
    if (m_busy && !reset && req[m_owner] && !fifo_full) begin
      grant = 1;
      exp_gnt[m_owner] = 1'b1;
    end
    exp_word = req_data[m_owner*DW +: DW];
    chk("gnt", 32'(gnt), 32'(exp_gnt));
    chk("wen", 32'(fifo_wen), 32'(grant));
    if (grant) chk("data", 32'(fifo_data_in), 32'(exp_word));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("owner", 32'(owner), 32'(m_owner));
    chk("rr_ptr", 32'(dbg_rr_ptr), 32'(m_rr));
    last_gnt = gnt;
    last_wen = fifo_wen;
    d_seen = fifo_data_in;
    @(posedge clk);
    if (rd_en) begin
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    if (last_wen) fifo_q.push_back(d_seen);
    if (grant) begin
      exp_q.push_back(exp_word);
      p_cnt[m_owner]++;
    end
    if (reset) begin
      m_busy = 0; m_rr = 0; m_owner = 0; m_cnt = 0;
    end else if (!m_busy) begin
      if (req != '0 && free >= BL) begin
        m_owner = pick(req, m_rr);
        m_cnt = 0;
        m_busy = 1;
      end
    end else if (grant) begin
      m_cnt++;
      if (req_last[m_owner] || m_cnt == BL) begin
        m_busy = 0;
        m_rr = (m_owner + 1) % N;
      end
    end
    @(negedge clk);
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  task automatic drain();
    req = '0;
    req_last = '0;
    rd_en = 1'b1;
    for (int k = 0; k < 40 && fifo_q.size() > 0; k++) cyc();
    rd_en = 1'b0;
    chk("drain_empty", 32'(fifo_q.size()), 32'd0);
  endtask

  task automatic set_word(input int i, input logic [DW-1:0] w);
    req_data[i*DW +: DW] = w;
  endtask

  task automatic compare_fifo(input string tag);
    chk({tag, "_size"}, 32'(fifo_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < fifo_q.size() && i < exp_q.size(); i++)
      chk({tag, "_word"}, 32'(fifo_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req = '0; req_last = '0; req_data = '0; rd_en = 1'b0;
    fifo_depth = '0; fifo_full = 1'b0; last_gnt = '0; last_wen = 1'b0;
    m_busy = 0; m_owner = 0; m_rr = 0; m_cnt = 0;
    for (int i = 0; i < N; i++) p_cnt[i] = 0;

    // reset state
    @(negedge clk);
    cyc();
    cyc();
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_rr", 32'(dbg_rr_ptr), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    reset = 1'b0;

    // single producer 2, words A0..A3
    req = 4'b0100;
    set_word(2, 16'h00A0);
    cyc();
    chk("t1_arb_gnt", 32'(last_gnt), 32'd0);
    chk("t1_owner", 32'(owner), 32'd2);
    for (int k = 0; k < 4; k++) begin
      set_word(2, 16'(16'h00A0 + k));
      req_last = (k == 3) ? 4'b0100 : 4'b0000;
      cyc();
      chk("t1_gnt", 32'(last_gnt), 32'b0100);
    end
    req = '0; req_last = '0;
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_rr", 32'(dbg_rr_ptr), 32'd3);
    chk("t1_fifo_size", 32'(fifo_q.size()), 32'd4);
    for (int k = 0; k < 4 && k < fifo_q.size(); k++)
      chk("t1_fifo_word", 32'(fifo_q[k]), 32'(16'h00A0 + k));
    drain();

    // round robin with all producers streaming
    reset_dut();
    for (int i = 0; i < N; i++) p_cnt[i] = 0;
    req = 4'b1111;
    rd_en = 1'b1;
    for (int c = 0; c < 25; c++) begin
      for (int i = 0; i < N; i++) set_word(i, 16'((i + 1) * 256 + p_cnt[i]));
      cyc();
      chk("rr_gnt", 32'(last_gnt), (c % 5 == 0) ? 32'd0 : (32'd1 << ((c / 5) % 4)));
    end
    chk("rr_cnt0", 32'(p_cnt[0]), 32'd8);
    chk("rr_cnt3", 32'(p_cnt[3]), 32'd4);
    compare_fifo("rr_fifo");
    drain();

    // space gating: depth 13 leaves room for only 3 words
    reset_dut();
    for (int k = 0; k < 13; k++) begin
      fifo_q.push_back(16'(16'h5500 + k));
      exp_q.push_back(16'(16'h5500 + k));
    end
    req = 4'b0001;
    set_word(0, 16'h0B00);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("gate_hold_gnt", 32'(last_gnt), 32'd0);
      chk("gate_hold_busy", 32'(busy), 32'd0);
    end
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    chk("gate_read_busy", 32'(busy), 32'd0);
    cyc();
    chk("gate_start", 32'(busy), 32'd1);
    for (int k = 0; k < 4; k++) begin
      set_word(0, 16'(16'h0B00 + k));
      cyc();
      chk("gate_gnt", 32'(last_gnt), 32'b0001);
    end
    chk("gate_full_size", 32'(fifo_q.size()), 32'd16);
    cyc();
    cyc();
    chk("gate_full_gnt", 32'(last_gnt), 32'd0);
    chk("gate_full_busy", 32'(busy), 32'd0);
    compare_fifo("gate_fifo");
    drain();

    // early last from producer 1
    req = 4'b0010;
    set_word(1, 16'h0C00);
    cyc();
    cyc();
    chk("early_gnt1", 32'(last_gnt), 32'b0010);
    set_word(1, 16'h0C01);
    req_last = 4'b0010;
    cyc();
    chk("early_gnt2", 32'(last_gnt), 32'b0010);
    req = '0; req_last = '0;
    chk("early_busy", 32'(busy), 32'd0);
    chk("early_rr", 32'(dbg_rr_ptr), 32'd2);
    chk("early_size", 32'(fifo_q.size()), 32'd2);
    drain();

    // bubble: producer 3 drops req for 2 cycles mid-burst
    req = 4'b1000;
    cyc();
    for (int k = 0; k < 2; k++) begin
      set_word(3, 16'(16'h0D00 + k));
      cyc();
      chk("bub_gnt_a", 32'(last_gnt), 32'b1000);
    end
    req = '0;
    for (int k = 0; k < 2; k++) begin
      cyc();
      chk("bub_gap_gnt", 32'(last_gnt), 32'd0);
      chk("bub_gap_wen", 32'(last_wen), 32'd0);
      chk("bub_gap_owner", 32'(owner), 32'd3);
      chk("bub_gap_busy", 32'(busy), 32'd1);
    end
    req = 4'b1000;
    for (int k = 2; k < 4; k++) begin
      set_word(3, 16'(16'h0D00 + k));
      cyc();
      chk("bub_gnt_b", 32'(last_gnt), 32'b1000);
    end
    req = '0;
    chk("bub_busy_end", 32'(busy), 32'd0);
    chk("bub_size", 32'(fifo_q.size()), 32'd4);
    drain();

    // reset after two beats
    req = 4'b0001;
    cyc();
    for (int k = 0; k < 2; k++) begin
      set_word(0, 16'(16'h0E00 + k));
      cyc();
    end
    set_word(0, 16'h0E02);
    reset = 1'b1;
    cyc();
    chk("rst_mid_gnt", 32'(last_gnt), 32'd0);
    reset = 1'b0;
    req = '0;
    cyc();
    chk("rst_mid_gnt_next", 32'(last_gnt), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_rr", 32'(dbg_rr_ptr), 32'd0);
    chk("rst_mid_size", 32'(fifo_q.size()), 32'd2);
    drain();

    // randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        req[i] = ($urandom_range(0, 9) < 7);
        req_last[i] = ($urandom_range(0, 3) == 0);
        set_word(i, 16'($urandom_range(0, 65535)));
      end
      rd_en = ($urandom_range(0, 2) == 0);
      cyc();
    end
    compare_fifo("rand_fifo");
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
